// File: rtl/pulse_acc_pkg.sv
// rtl/pulse_acc_pkg.sv - shared types and width helpers for the pulse-gated accumulator
package pulse_acc_pkg;

    localparam int DEF_DATA_WIDTH = 14;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int DEF_IDX_WIDTH  = 16;

    function automatic int sum_width(input int data_width, input int cnt_width);
        return data_width + cnt_width;
    endfunction

    localparam int DEF_SUM_WIDTH = sum_width(DEF_DATA_WIDTH, DEF_CNT_WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    typedef struct packed {
        logic signed [DEF_SUM_WIDTH-1:0] sum;
        logic [DEF_CNT_WIDTH-1:0]        count;
        logic [DEF_IDX_WIDTH-1:0]        index;
        logic                            sat;
    } result_t;

endpackage

// File: rtl/pulse_gated_accumulator_if.sv
// rtl/pulse_gated_accumulator_if.sv - result record stream between accumulator and readout
interface pulse_gated_accumulator_if #(
    parameter int SUM_WIDTH = 30,
    parameter int CNT_WIDTH = 16,
    parameter int IDX_WIDTH = 16
);
    logic                        m_valid;
    logic                        m_ready;
    logic signed [SUM_WIDTH-1:0] m_sum;
    logic [CNT_WIDTH-1:0]        m_count;
    logic [IDX_WIDTH-1:0]        m_index;
    logic                        m_sat;

    modport master (
        output m_valid, m_sum, m_count, m_index, m_sat,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_sum, m_count, m_index, m_sat,
        output m_ready
    );
endinterface

// File: rtl/result_fifo2.sv
// rtl/result_fifo2.sv - two-entry registered FIFO; head entry drives the output stream
module result_fifo2
    import pulse_acc_pkg::*;
#(
    parameter type T = result_t
) (
    input  logic clk,
    input  logic aresetn,
    input  logic push,
    input  T     push_data,
    output logic full,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    T           mem_q [2];
    T           mem_d [2];
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [1:0] cnt_q, cnt_d;
    logic       pop;
    logic       wr_en;

    assign out_valid = (cnt_q != 2'd0);
    assign full      = (cnt_q == 2'd2);
    assign out_data  = mem_q[rd_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop   = out_valid & out_ready;
    assign wr_en = push & (!full | pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (wr_en) begin
            mem_d[wr_q] = push_data;
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            mem_q <= '{default: '0};
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pulse_gated_accumulator.sv
// rtl/pulse_gated_accumulator.sv - sums signed ADC samples over each pulse window and
// emits one {sum, count, index, sat} record per pulse through a 2-entry buffer
module pulse_gated_accumulator
    import pulse_acc_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int CNT_WIDTH  = 16,
    parameter int IDX_WIDTH  = 16,
    parameter int SUM_WIDTH  = sum_width(DATA_WIDTH, CNT_WIDTH)
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic                         pulse,
    input  logic signed [DATA_WIDTH-1:0] adc_data,
    input  logic                         clr,
    pulse_gated_accumulator_if.master    m,
    output logic                         overflow,
    output logic [15:0]                  drop_count
);

    typedef struct packed {
        logic signed [SUM_WIDTH-1:0] sum;
        logic [CNT_WIDTH-1:0]        count;
        logic [IDX_WIDTH-1:0]        index;
        logic                        sat;
    } rec_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                      state_q, state_d;
    logic                        pulse_d_q;
    logic signed [SUM_WIDTH-1:0] sum_q, sum_d;
    logic [CNT_WIDTH-1:0]        count_q, count_d;
    logic                        sat_q, sat_d;
    logic [IDX_WIDTH-1:0]        idx_q, idx_d;
    logic                        ovf_q, ovf_d;
    logic [15:0]                 drop_q, drop_d;

    logic                        push;
    logic                        drop;
    logic                        pop;
    logic                        full;
    logic                        out_valid;
    rec_t                        push_rec;
    rec_t                        out_rec;
    logic signed [SUM_WIDTH-1:0] sample_ext;

    assign sample_ext = {{(SUM_WIDTH-DATA_WIDTH){adc_data[DATA_WIDTH-1]}}, adc_data};

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;
        sat_d   = sat_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pulse && !pulse_d_q) begin
                    sum_d   = sample_ext;
                    count_d = CNT_WIDTH'(1);
                    sat_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // The falling-edge sample is not part of the window.
                if (!pulse) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else if (count_q == CNT_MAX) begin
                    sat_d = 1'b1;
                end else begin
                    sum_d   = sum_q + sample_ext;
                    count_d = count_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign push_rec = '{sum: sum_q, count: count_q, index: idx_q, sat: sat_q};
    assign pop      = out_valid & m.m_ready;
    assign drop     = push & full & !pop;

    always_comb begin
        idx_d  = idx_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clr) begin
            idx_d  = '0;
            ovf_d  = 1'b0;
            drop_d = 16'd0;
        end else begin
            if (push) begin
                idx_d = idx_q + IDX_WIDTH'(1);
            end
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end
        end
    end

    // pulse_d resets high so a pulse already asserted at release is not a rising edge.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            pulse_d_q <= 1'b1;
            sum_q     <= '0;
            count_q   <= '0;
            sat_q     <= 1'b0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            pulse_d_q <= pulse;
            sum_q     <= sum_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
        end
    end

    result_fifo2 #(
        .T(rec_t)
    ) u_fifo (
        .clk      (clk),
        .aresetn  (aresetn),
        .push     (push),
        .push_data(push_rec),
        .full     (full),
        .out_valid(out_valid),
        .out_ready(m.m_ready),
        .out_data (out_rec)
    );

    assign m.m_valid  = out_valid;
    assign m.m_sum    = out_rec.sum;
    assign m.m_count  = out_rec.count;
    assign m.m_index  = out_rec.index;
    assign m.m_sat    = out_rec.sat;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_pulse_gated_accumulator.sv
// tb/tb_pulse_gated_accumulator.sv - scoreboard bench for pulse_gated_accumulator
module tb_pulse_gated_accumulator;

    typedef struct {
        longint sum;
        int     count;
        int     index;
        bit     sat;
    } exp_t;

    logic              clk = 1'b0;
    logic              aresetn = 1'b0;
    logic              pulse = 1'b0;
    logic signed [13:0] adc_data = '0;
    logic              clr = 1'b0;
    logic              overflow;
    logic [15:0]       drop_count;

    logic              pulse4 = 1'b0;
    logic signed [13:0] adc4 = '0;
    logic              overflow4;
    logic [15:0]       drop_count4;

    pulse_gated_accumulator_if #(.SUM_WIDTH(30), .CNT_WIDTH(16), .IDX_WIDTH(16)) sif ();
    pulse_gated_accumulator_if #(.SUM_WIDTH(18), .CNT_WIDTH(4),  .IDX_WIDTH(16)) sif4 ();

    pulse_gated_accumulator dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .pulse     (pulse),
        .adc_data  (adc_data),
        .clr       (clr),
        .m         (sif),
        .overflow  (overflow),
        .drop_count(drop_count)
    );

    pulse_gated_accumulator #(.CNT_WIDTH(4)) dut4 (
        .clk       (clk),
        .aresetn   (aresetn),
        .pulse     (pulse4),
        .adc_data  (adc4),
        .clr       (1'b0),
        .m         (sif4),
        .overflow  (overflow4),
        .drop_count(drop_count4)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];
    exp_t sb4[$];
    int   exp_idx = 0;
    int   exp_idx4 = 0;

    always @(negedge clk) begin
        if (aresetn && sif.m_valid && sif.m_ready) begin
            exp_t   e;
            longint s;
            s = sif.m_sum;
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL record_unexpected: got sum=%0d count=%0d index=%0d, required none", s, sif.m_count, sif.m_index);
            end else begin
                e = sb.pop_front();
                if (s !== e.sum || sif.m_count !== e.count[15:0] || sif.m_index !== e.index[15:0] || sif.m_sat !== e.sat)
                    $display("FAIL record: got sum=%0d count=%0d index=%0d sat=%0d, required sum=%0d count=%0d index=%0d sat=%0d",
                             s, sif.m_count, sif.m_index, sif.m_sat, e.sum, e.count, e.index, e.sat);
                else
                    passed++;
            end
        end
    end

    always @(negedge clk) begin
        if (aresetn && sif4.m_valid && sif4.m_ready) begin
            exp_t   e;
            longint s;
            s = sif4.m_sum;
            checks++;
            if (sb4.size() == 0) begin
                $display("FAIL record4_unexpected: got sum=%0d count=%0d, required none", s, sif4.m_count);
            end else begin
                e = sb4.pop_front();
                if (s !== e.sum || sif4.m_count !== e.count[3:0] || sif4.m_index !== e.index[15:0] || sif4.m_sat !== e.sat)
                    $display("FAIL record4: got sum=%0d count=%0d index=%0d sat=%0d, required sum=%0d count=%0d index=%0d sat=%0d",
                             s, sif4.m_count, sif4.m_index, sif4.m_sat, e.sum, e.count, e.index, e.sat);
                else
                    passed++;
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic exp_t model(input int width, input int base, input int step, input int cnt_max, input int index);
        exp_t e;
        e.sum = 0; e.count = 0; e.sat = 1'b0; e.index = index;
        for (int i = 0; i < width; i++) begin
            if (e.count == cnt_max) e.sat = 1'b1;
            else begin
                e.sum += longint'(base + i * step);
                e.count++;
            end
        end
        return e;
    endfunction

    task automatic apply_reset();
        aresetn = 1'b0;
        pulse = 1'b0;
        pulse4 = 1'b0;
        clr = 1'b0;
        cyc(2);
        aresetn = 1'b1;
        sb.delete();
        sb4.delete();
        exp_idx = 0;
        exp_idx4 = 0;
        cyc(1);
    endtask

    task automatic send_pulse(input int width, input int base, input int step, input int gap, input bit keep, input bit clr_fall);
        exp_t e;
        e = model(width, base, step, 65535, exp_idx);
        if (keep) sb.push_back(e);
        exp_idx = clr_fall ? 0 : exp_idx + 1;
        for (int i = 0; i < width; i++) begin
            pulse = 1'b1;
            adc_data = 14'(base + i * step);
            cyc(1);
        end
        pulse = 1'b0;
        adc_data = 14'(1234);
        clr = clr_fall;
        cyc(1);
        clr = 1'b0;
        if (gap > 1) cyc(gap - 1);
    endtask

    task automatic send_pulse4(input int width, input int base);
        sb4.push_back(model(width, base, 0, 15, exp_idx4));
        exp_idx4++;
        for (int i = 0; i < width; i++) begin
            pulse4 = 1'b1;
            adc4 = 14'(base);
            cyc(1);
        end
        pulse4 = 1'b0;
        cyc(3);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || sb4.size() != 0) && n < 300) begin
            cyc(1);
            n++;
        end
        checks++;
        if (sb.size() == 0 && sb4.size() == 0) passed++;
        else $display("FAIL %s_drain: got %0d/%0d records pending, required 0", name, sb.size(), sb4.size());
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 4;
        if (sif.m_valid !== 1'b0) $display("FAIL reset_valid: got %0b, required 0", sif.m_valid); else passed++;
        if (sif.m_sum !== '0 || sif.m_count !== '0 || sif.m_index !== '0 || sif.m_sat !== 1'b0)
            $display("FAIL reset_fields: got sum=%0d count=%0d index=%0d sat=%0b, required 0", sif.m_sum, sif.m_count, sif.m_index, sif.m_sat);
        else passed++;
        if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0b, required 0", overflow); else passed++;
        if (drop_count !== 16'd0) $display("FAIL reset_drop_count: got %0d, required 0", drop_count); else passed++;
    endtask

    task automatic test_basic();
        sif.m_ready = 1'b1;
        for (int p = 0; p < 3; p++) send_pulse(10, 100, 0, 90, 1'b1, 1'b0);
        wait_drain("basic");
    endtask

    task automatic test_ramp();
        exp_t e;
        send_pulse(10, -5, 1, 5, 1'b1, 1'b0);
        wait_drain("ramp");
        e = model(1, -8192, 0, 65535, exp_idx);
        sb.push_back(e);
        exp_idx++;
        pulse = 1'b1;
        adc_data = 14'(-8192);
        cyc(1);
        checks++;
        if (sif.m_valid !== 1'b0) $display("FAIL width1_early_valid: got %0b, required 0", sif.m_valid); else passed++;
        pulse = 1'b0;
        adc_data = 14'(77);
        cyc(1);
        checks++;
        if (sif.m_valid !== 1'b1) $display("FAIL width1_latency: got valid=%0b, required 1", sif.m_valid); else passed++;
        wait_drain("width1");
    endtask

    task automatic test_backpressure();
        apply_reset();
        sif.m_ready = 1'b0;
        send_pulse(4, 10, 0, 3, 1'b1, 1'b0);
        send_pulse(4, 20, 0, 3, 1'b1, 1'b0);
        send_pulse(4, 30, 0, 3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            longint s;
            s = sif.m_sum;
            checks++;
            if (sif.m_valid !== 1'b1 || s !== sb[0].sum || sif.m_index !== 16'd0)
                $display("FAIL hold_stable: got valid=%0b sum=%0d index=%0d, required valid=1 sum=%0d index=0", sif.m_valid, s, sif.m_index, sb[0].sum);
            else passed++;
            cyc(1);
        end
        checks += 2;
        if (overflow !== 1'b1) $display("FAIL bp_overflow: got %0b, required 1", overflow); else passed++;
        if (drop_count !== 16'd1) $display("FAIL bp_drop_count: got %0d, required 1", drop_count); else passed++;
        sif.m_ready = 1'b1;
        wait_drain("bp");
        send_pulse(4, 40, 0, 3, 1'b1, 1'b0);
        wait_drain("bp_next");
    endtask

    task automatic test_clr_push();
        send_pulse(3, 9, 0, 3, 1'b1, 1'b1);
        send_pulse(3, -9, 0, 3, 1'b1, 1'b0);
        wait_drain("clr");
        checks += 2;
        if (overflow !== 1'b0) $display("FAIL clr_overflow: got %0b, required 0", overflow); else passed++;
        if (drop_count !== 16'd0) $display("FAIL clr_drop_count: got %0d, required 0", drop_count); else passed++;
    endtask

    task automatic test_reset_mid_pulse();
        bit seen;
        pulse = 1'b1;
        adc_data = 14'(50);
        cyc(4);
        aresetn = 1'b0;
        sb.delete();
        exp_idx = 0;
        cyc(2);
        aresetn = 1'b1;
        cyc(3);
        pulse = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (sif.m_valid) seen = 1'b1;
            cyc(1);
        end
        checks++;
        if (seen) $display("FAIL reset_mid_no_record: got valid=1, required 0"); else passed++;
        send_pulse(6, 7, 0, 4, 1'b1, 1'b0);
        wait_drain("reset_mid");
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 4; p++) send_pulse(2, 100 * p - 150, 3, 1, 1'b1, 1'b0);
        wait_drain("b2b");
        checks++;
        if (overflow !== 1'b0 || drop_count !== 16'd0)
            $display("FAIL b2b_no_drop: got overflow=%0b drops=%0d, required 0/0", overflow, drop_count);
        else passed++;
    endtask

    task automatic test_saturation();
        sif4.m_ready = 1'b1;
        send_pulse4(20, 3);
        send_pulse4(5, -2);
        wait_drain("sat");
        checks++;
        if (overflow4 !== 1'b0 || drop_count4 !== 16'd0)
            $display("FAIL sat_no_drop: got overflow=%0b drops=%0d, required 0/0", overflow4, drop_count4);
        else passed++;
    endtask

    initial begin
        sif.m_ready = 1'b0;
        sif4.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_ramp();
        test_backpressure();
        test_clr_push();
        test_reset_mid_pulse();
        test_back_to_back();
        test_saturation();
        cyc(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
